// File: rtl/buffer_write_arbiter.sv
// Round-robin write-port arbiter for a shared circular buffer, with a drain/flush sequencer
// and a shadow occupancy counter.
module buffer_write_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]     req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         buf_write_en,
  output logic [WIDTH-1:0]             buf_write_data,
  output logic                         buf_read_en,
  input  logic                         buf_full,
  input  logic                         buf_empty,
  input  logic                         flush_req,
  output logic                         flush_busy,
  output logic                         flush_done,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_idx
);

  localparam int unsigned PW = $clog2(NUM_REQ);
  localparam int unsigned OW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [OW-1:0]   occ_q, occ_d;

  logic [WIDTH-1:0] req_data_arr [NUM_REQ];
  logic             grant_found;
  logic [PW-1:0]    grant_sel;
  logic [PW-1:0]    idx;
  logic             wr_inc, rd_dec;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_data_arr[i] = req_data[i*WIDTH +: WIDTH];
  end

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_sel   = '0;
    idx         = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = PW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_sel   = idx;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    req_ready      = '0;
    buf_write_en   = 1'b0;
    buf_write_data = '0;
    buf_read_en    = 1'b0;
    flush_busy     = 1'b0;
    flush_done     = 1'b0;
    grant_idx      = '0;
    unique case (state_q)
      StRun: begin
        // Reset gates the combinational grant so outputs are quiet while held in reset.
        if (reset && !buf_full && grant_found) begin
          req_ready[grant_sel] = 1'b1;
          buf_write_en         = 1'b1;
          buf_write_data       = req_data_arr[grant_sel];
          grant_idx            = grant_sel;
          rr_ptr_d             = (grant_sel == PW'(NUM_REQ - 1)) ? '0 : grant_sel + PW'(1);
        end
        if (flush_req) state_d = StDrain;
      end
      StDrain: begin
        flush_busy  = 1'b1;
        buf_read_en = !buf_empty;
        if (buf_empty) state_d = StDone;
      end
      StDone: begin
        flush_done = 1'b1;
        state_d    = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  assign wr_inc = buf_write_en && !buf_full;
  assign rd_dec = buf_read_en && !buf_empty;

  // Saturating shadow count; simultaneous push and pop cancel.
  always_comb begin
    occ_d = occ_q;
    if (wr_inc && !rd_dec && occ_q != OW'(DEPTH)) begin
      occ_d = occ_q + OW'(1);
    end else if (rd_dec && !wr_inc && occ_q != '0) begin
      occ_d = occ_q - OW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StRun;
      rr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_buffer_write_arbiter.sv
// Directed bench for buffer_write_arbiter: arbitration, full back-pressure, drain sequencing
// and reset abort, with the buffer flags driven by hand.
module tb_buffer_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic        buf_write_en;
  logic [31:0] buf_write_data;
  logic        buf_read_en;
  logic        buf_full;
  logic        buf_empty;
  logic        flush_req;
  logic        flush_busy;
  logic        flush_done;
  logic [2:0]  occupancy;
  logic [0:0]  grant_idx;

  int n_checks = 0;
  int n_fail   = 0;

  buffer_write_arbiter #(
    .WIDTH   (32),
    .NUM_REQ (2),
    .DEPTH   (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .buf_write_en   (buf_write_en),
    .buf_write_data (buf_write_data),
    .buf_read_en    (buf_read_en),
    .buf_full       (buf_full),
    .buf_empty      (buf_empty),
    .flush_req      (flush_req),
    .flush_busy     (flush_busy),
    .flush_done     (flush_done),
    .occupancy      (occupancy),
    .grant_idx      (grant_idx)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    req_valid = 2'b11;
    req_data  = '0;
    buf_full  = 1'b0;
    buf_empty = 1'b1;
    flush_req = 1'b0;
    #1;
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_we", 32'(buf_write_en), 32'd0);
    check_eq("rst_re", 32'(buf_read_en), 32'd0);
    check_eq("rst_busy", 32'(flush_busy), 32'd0);
    check_eq("rst_done", 32'(flush_done), 32'd0);
    check_eq("rst_gidx", 32'(grant_idx), 32'd0);
    check_eq("rst_occ", 32'(occupancy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    req_valid = 2'b00;
    reset     = 1'b1;
    #1;

    // Four writes from requester 0, then the buffer reports full.
    buf_empty = 1'b0;
    req_valid = 2'b01;
    for (int i = 0; i < 4; i++) begin
      req_data[31:0] = 32'hA0 + 32'(i);
      #1;
      check_eq("t1_ready", 32'(req_ready), 32'd1);
      check_eq("t1_we", 32'(buf_write_en), 32'd1);
      check_eq("t1_data", buf_write_data, 32'hA0 + 32'(i));
      check_eq("t1_gidx", 32'(grant_idx), 32'd0);
      tick();
      check_eq("t1_occ", 32'(occupancy), 32'(i + 1));
    end
    buf_full = 1'b1;
    #1;
    check_eq("t1_full_ready", 32'(req_ready), 32'd0);
    check_eq("t1_full_we", 32'(buf_write_en), 32'd0);
    tick();
    check_eq("t1_full_occ", 32'(occupancy), 32'd4);
    buf_full  = 1'b0;
    req_valid = 2'b00;
    do_reset();

    // Both requesters valid: strict alternation starting at 0.
    req_data  = {32'hC0, 32'hB0};
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("t2_ready", 32'(req_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
      check_eq("t2_gidx", 32'(grant_idx), 32'(i % 2));
      check_eq("t2_data", buf_write_data, (i % 2 == 0) ? 32'hB0 : 32'hC0);
      tick();
    end
    check_eq("t2_occ", 32'(occupancy), 32'd4);

    // Move pointer to 1, hold off while full, then resume at requester 1.
    req_valid = 2'b01;
    #1;
    check_eq("t3_pre_ready", 32'(req_ready), 32'd1);
    tick();
    check_eq("t3_occ_sat", 32'(occupancy), 32'd4);
    req_valid = 2'b11;
    buf_full  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("t3_full_ready", 32'(req_ready), 32'd0);
      check_eq("t3_full_we", 32'(buf_write_en), 32'd0);
      tick();
    end
    buf_full = 1'b0;
    #1;
    check_eq("t3_resume_ready", 32'(req_ready), 32'd2);
    check_eq("t3_resume_gidx", 32'(grant_idx), 32'd1);
    check_eq("t3_resume_data", buf_write_data, 32'hC0);
    tick();
    req_valid = 2'b00;

    // Three entries (last written alongside flush_req), then drain.
    do_reset();
    buf_empty = 1'b0;
    req_valid = 2'b01;
    req_data  = {32'hC0, 32'hD0};
    tick();
    tick();
    flush_req = 1'b1;
    #1;
    check_eq("t4_flush_cyc_we", 32'(buf_write_en), 32'd1);
    check_eq("t4_flush_cyc_busy", 32'(flush_busy), 32'd0);
    tick();
    flush_req = 1'b0;
    check_eq("t4_occ3", 32'(occupancy), 32'd3);
    req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("t4_busy", 32'(flush_busy), 32'd1);
      check_eq("t4_re", 32'(buf_read_en), 32'd1);
      check_eq("t4_ready", 32'(req_ready), 32'd0);
      check_eq("t4_we", 32'(buf_write_en), 32'd0);
      tick();
      check_eq("t4_occ", 32'(occupancy), 32'(2 - i));
    end
    buf_empty = 1'b1;
    #1;
    check_eq("t4_empty_busy", 32'(flush_busy), 32'd1);
    check_eq("t4_empty_re", 32'(buf_read_en), 32'd0);
    tick();
    check_eq("t4_done", 32'(flush_done), 32'd1);
    check_eq("t4_done_busy", 32'(flush_busy), 32'd0);
    check_eq("t4_done_ready", 32'(req_ready), 32'd0);
    tick();
    check_eq("t4_after_done", 32'(flush_done), 32'd0);
    check_eq("t4_after_ready", 32'(req_ready), 32'd2);
    tick();
    req_valid = 2'b00;

    // Flush of an already-empty buffer.
    do_reset();
    buf_empty = 1'b1;
    flush_req = 1'b1;
    #1;
    check_eq("t5_run_busy", 32'(flush_busy), 32'd0);
    tick();
    flush_req = 1'b0;
    check_eq("t5_drain_busy", 32'(flush_busy), 32'd1);
    check_eq("t5_drain_re", 32'(buf_read_en), 32'd0);
    check_eq("t5_drain_done", 32'(flush_done), 32'd0);
    tick();
    check_eq("t5_done", 32'(flush_done), 32'd1);
    check_eq("t5_done_busy", 32'(flush_busy), 32'd0);
    tick();
    check_eq("t5_after_done", 32'(flush_done), 32'd0);
    check_eq("t5_occ", 32'(occupancy), 32'd0);

    // Reset during the second drain cycle aborts the flush.
    do_reset();
    buf_empty = 1'b0;
    req_valid = 2'b01;
    tick();
    tick();
    req_valid = 2'b00;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    check_eq("t6_drain1_re", 32'(buf_read_en), 32'd1);
    tick();
    check_eq("t6_drain2_busy", 32'(flush_busy), 32'd1);
    check_eq("t6_drain2_occ", 32'(occupancy), 32'd1);
    req_valid = 2'b11;
    reset     = 1'b0;
    #1;
    check_eq("t6_rst_busy", 32'(flush_busy), 32'd0);
    check_eq("t6_rst_re", 32'(buf_read_en), 32'd0);
    check_eq("t6_rst_occ", 32'(occupancy), 32'd0);
    check_eq("t6_rst_ready", 32'(req_ready), 32'd0);
    check_eq("t6_rst_done", 32'(flush_done), 32'd0);
    tick();
    reset = 1'b1;
    #1;
    check_eq("t6_rel_done", 32'(flush_done), 32'd0);
    check_eq("t6_rel_busy", 32'(flush_busy), 32'd0);
    check_eq("t6_rel_ready", 32'(req_ready), 32'd1);
    req_valid = 2'b00;
    tick();
    check_eq("t6_post_done", 32'(flush_done), 32'd0);
    check_eq("t6_post_occ", 32'(occupancy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/buffer_write_arbiter.md
Name: buffer_write_arbiter

Overview:
Shares the write port of one circular_buffer instance among NUM_REQ requesters, for example the decode lanes feeding a shared instruction queue. Arbitration is round-robin, at most one write per cycle. The block also sequences a drain/flush of the buffer: it stops accepting writes, pops the buffer until it is empty, then signals completion. It sits beside the circular_buffer and drives that buffer's write_en, write_data and read_en, and observes its full and empty.

Parameters:
WIDTH, 32, data width of each requester and of the buffer entries
NUM_REQ, 2, number of requesters (2..8)
DEPTH, 4, depth of the attached buffer; sizes the occupancy counter

Ports:
clk  in  1  clock, all state changes on rising edge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
req_valid  in  NUM_REQ  per-requester write request
req_data  in  NUM_REQ*WIDTH  packed payloads; requester i occupies bits [i*WIDTH +: WIDTH]
req_ready  out  NUM_REQ  one-hot-or-zero grant; a transfer happens when req_valid[i] and req_ready[i] are both 1
buf_write_en  out  1  write strobe to the buffer
buf_write_data  out  WIDTH  payload of the granted requester
buf_read_en  out  1  pop strobe to the buffer, asserted only during drain
buf_full  in  1  buffer full flag
buf_empty  in  1  buffer empty flag
flush_req  in  1  single-cycle pulse requesting a drain
flush_busy  out  1  high while a drain is in progress
flush_done  out  1  single-cycle pulse when the drain completes
occupancy  out  $clog2(DEPTH+1)  shadow count of buffer entries
grant_idx  out  $clog2(NUM_REQ)  index of the current grant; valid when buf_write_en=1

Behaviour:
- Reset (reset=0, asynchronous): FSM=RUN, rr_ptr=0, occupancy=0. req_ready, buf_write_en, buf_read_en, flush_busy, flush_done and grant_idx are all 0.
- FSM states: RUN, DRAIN, DONE.
- RUN:
  - Grant is combinational and has zero latency.
  - If buf_full=0, grant the first requester with valid=1, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - buf_write_en = any grant. buf_write_data = req_data of the granted requester.
  - If buf_full=1, req_ready=0 and buf_write_en=0.
  - req_ready never depends on whether the requester asserts valid beyond its own grant.
- Round-robin pointer: after a cycle with a grant to requester g, rr_ptr becomes (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Fairness: a requester that holds req_valid high continuously is granted within NUM_REQ write-eligible cycles.
- flush_req seen in RUN:
  - Next state is DRAIN.
  - A grant in the same cycle as flush_req still completes.
- flush_req seen outside RUN is ignored.
- DRAIN:
  - req_ready=0, buf_write_en=0, flush_busy=1.
  - buf_read_en = !buf_empty.
  - When buf_empty=1, the next state is DONE.
  - Entering DRAIN with the buffer already empty still takes one DRAIN cycle with buf_read_en=0.
- DONE: flush_done=1 and flush_busy=0 for exactly one cycle, then back to RUN. rr_ptr is preserved across the flush.
- Occupancy counter:
  - +1 on buf_write_en&&!buf_full.
  - -1 on buf_read_en&&!buf_empty.
  - A write and a read in the same cycle leave it unchanged (this cannot happen in the current FSM, but the logic must handle it).
  - Saturates at 0 and at DEPTH, never wraps.
- Reset asserted mid-drain aborts immediately. No flush_done is produced.
- Requesters must hold req_valid and req_data stable until granted. The block does not check this.

Test Plan:
- Reset, then req_valid=2'b01 with data 32'hA0..A3 over 4 cycles -> four grants to requester 0, buf_write_en=1 each cycle, occupancy 1,2,3,4, buf_full=1 after the 4th write; a 5th request gets req_ready=0.
- Both valid continuously, data r0=32'hB0, r1=32'hC0, buffer not full -> grants alternate 0,1,0,1; grant_idx toggles each cycle; write data alternates B0/C0.
- Both valid while buf_full=1 for 3 cycles, then buf_full=0 -> no grants and rr_ptr unchanged during the full cycles; the first grant goes to the requester rr_ptr points at.
- Buffer holds 3 entries, pulse flush_req -> next cycle flush_busy=1 and buf_read_en=1 for 3 cycles, occupancy 3->0; buf_empty causes DONE; flush_done pulses once; requester writes resume the following cycle.
- flush_req pulsed with the buffer empty -> one DRAIN cycle with buf_read_en=0, then a flush_done pulse; occupancy stays 0.
- Assert reset=0 during the 2nd DRAIN cycle -> all outputs 0 immediately; after release FSM=RUN, occupancy=0, no flush_done.
